// File: rtl/execute_and_writeback_pkg.sv
// Shared definitions for the execute/writeback stage: opcodes, FSM states,
// flag bit positions and operand-usage decode helpers.
package execute_and_writeback_pkg;

    typedef enum logic [3:0] {
        OP_NOP   = 4'h0,
        OP_ADD   = 4'h1,
        OP_SUB   = 4'h2,
        OP_AND   = 4'h3,
        OP_OR    = 4'h4,
        OP_XOR   = 4'h5,
        OP_NOT   = 4'h6,
        OP_SLL   = 4'h7,
        OP_SRL   = 4'h8,
        OP_SRA   = 4'h9,
        OP_RSV0  = 4'hA,
        OP_RSV1  = 4'hB,
        OP_RSV2  = 4'hC,
        OP_RSV3  = 4'hD,
        OP_LOAD  = 4'hE,
        OP_STORE = 4'hF
    } opcode_e;

    typedef enum logic {
        IDLE = 1'b0,
        MEM  = 1'b1
    } state_e;

    localparam int unsigned FLAG_ZERO  = 0;
    localparam int unsigned FLAG_CARRY = 1;
    localparam int unsigned FLAG_NEG   = 2;

    function automatic logic isAluOp(input opcode_e op);
        return (op >= OP_ADD) && (op <= OP_SRA);
    endfunction

    function automatic logic readsSrc1(input opcode_e op);
        return isAluOp(op) || (op == OP_STORE);
    endfunction

    function automatic logic readsSrc2(input opcode_e op);
        return isAluOp(op) && (op != OP_NOT);
    endfunction

endpackage

// File: rtl/execute_and_writeback_alu16.sv
// Combinational ALU: opcode/src1/src2 -> result and carry (carry out of ADD,
// borrow of SUB, zero otherwise).
module alu16
    import execute_and_writeback_pkg::*;
#(
    parameter int unsigned DATA_W = 16
) (
    input  opcode_e           opcode,
    input  logic [DATA_W-1:0] src1,
    input  logic [DATA_W-1:0] src2,
    output logic [DATA_W-1:0] result,
    output logic              carry
);

    always_comb begin
        result = '0;
        carry  = 1'b0;
        case (opcode)
            OP_ADD: {carry, result} = {1'b0, src1} + {1'b0, src2};
            OP_SUB: begin
                result = src1 - src2;
                carry  = (src1 < src2);
            end
            OP_AND: result = src1 & src2;
            OP_OR:  result = src1 | src2;
            OP_XOR: result = src1 ^ src2;
            OP_NOT: result = ~src1;
            OP_SLL: result = src1 << src2[3:0];
            OP_SRL: result = src1 >> src2[3:0];
            OP_SRA: result = $signed(src1) >>> src2[3:0];
            default: begin
                result = '0;
                carry  = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/execute_and_writeback.sv
// Execute/writeback stage: single-cycle ALU ops, req/ack LOAD/STORE with
// timeout, operand-hazard stall and register-file writeback.
module execute_and_writeback
    import execute_and_writeback_pkg::*;
#(
    parameter int unsigned DATA_W      = 16,
    parameter int unsigned ADDR_W      = 8,
    parameter int unsigned MEM_TIMEOUT = 15
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [3:0]        opcode,
    input  logic [3:0]        destReg,
    input  logic [DATA_W-1:0] srcVal1,
    input  logic [DATA_W-1:0] srcVal2,
    input  logic [ADDR_W-1:0] memAddr,
    input  logic              used1,
    input  logic              used2,
    output logic              stall,
    output logic              wb_en,
    output logic [3:0]        wb_reg,
    output logic [DATA_W-1:0] wb_data,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ack,
    output logic [2:0]        flags,
    output logic              mem_err
);

    state_e            state, nextState;
    opcode_e           op;
    logic              hazard, isMem, accept, memFinish, memTimeout;
    logic              memDone;
    logic [7:0]        timeoutCnt;
    logic [3:0]        pendReg;
    logic [DATA_W-1:0] aluResult;
    logic              aluCarry;

    assign op     = opcode_e'(opcode);
    assign hazard = (readsSrc1(op) && used1) || (readsSrc2(op) && used2);
    assign isMem  = (op == OP_LOAD) || (op == OP_STORE);

    alu16 #(.DATA_W(DATA_W)) u_alu (
        .opcode (op),
        .src1   (srcVal1),
        .src2   (srcVal2),
        .result (aluResult),
        .carry  (aluCarry)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= nextState;
    end

    // Decode holds the memory op while stalled, so the cycle right after MEM
    // still presents that stale op; memDone keeps it from being re-issued.
    always_comb begin
        nextState  = state;
        stall      = 1'b0;
        accept     = 1'b0;
        memFinish  = 1'b0;
        memTimeout = 1'b0;
        case (state)
            IDLE: begin
                if (!memDone) begin
                    if (hazard) begin
                        stall = 1'b1;
                    end else begin
                        accept = 1'b1;
                        if (isMem) begin
                            stall     = 1'b1;
                            nextState = MEM;
                        end
                    end
                end
            end
            MEM: begin
                stall = 1'b1;
                if (mem_ack) begin
                    memFinish = 1'b1;
                    nextState = IDLE;
                end else if (timeoutCnt == 8'(MEM_TIMEOUT - 1)) begin
                    memTimeout = 1'b1;
                    nextState  = IDLE;
                end
            end
            default: nextState = IDLE;
        endcase
        if (!rst) stall = 1'b0;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wb_en      <= 1'b0;
            wb_reg     <= '0;
            wb_data    <= '0;
            flags      <= '0;
            mem_req    <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            mem_err    <= 1'b0;
            memDone    <= 1'b0;
            timeoutCnt <= '0;
            pendReg    <= '0;
        end else begin
            wb_en   <= 1'b0;
            memDone <= 1'b0;
            if (accept && isAluOp(op)) begin
                wb_en            <= 1'b1;
                wb_reg           <= destReg;
                wb_data          <= aluResult;
                flags[FLAG_NEG]  <= aluResult[DATA_W-1];
                flags[FLAG_CARRY] <= aluCarry;
                flags[FLAG_ZERO] <= (aluResult == '0);
            end
            if (accept && isMem) begin
                mem_req    <= 1'b1;
                mem_we     <= (op == OP_STORE);
                mem_addr   <= memAddr;
                mem_wdata  <= srcVal1;
                pendReg    <= destReg;
                timeoutCnt <= '0;
            end
            if (state == MEM && !memFinish && !memTimeout)
                timeoutCnt <= timeoutCnt + 8'd1;
            if (memFinish) begin
                mem_req <= 1'b0;
                memDone <= 1'b1;
                if (!mem_we) begin
                    wb_en   <= 1'b1;
                    wb_reg  <= pendReg;
                    wb_data <= mem_rdata;
                end
            end
            if (memTimeout) begin
                mem_req <= 1'b0;
                memDone <= 1'b1;
                mem_err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_execute_and_writeback.sv
// Directed self-checking bench for execute_and_writeback.
module tb_execute_and_writeback;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  opcode, destReg;
    logic [15:0] srcVal1, srcVal2, mem_rdata, wb_data, mem_wdata;
    logic [7:0]  memAddr, mem_addr;
    logic        used1, used2, mem_ack;
    logic        stall, wb_en, mem_req, mem_we, mem_err;
    logic [3:0]  wb_reg;
    logic [2:0]  flags;

    int checks   = 0;
    int failures = 0;

    execute_and_writeback #(.DATA_W(16), .ADDR_W(8), .MEM_TIMEOUT(15)) dut (
        .clk(clk), .rst(rst), .opcode(opcode), .destReg(destReg),
        .srcVal1(srcVal1), .srcVal2(srcVal2), .memAddr(memAddr),
        .used1(used1), .used2(used2), .stall(stall), .wb_en(wb_en),
        .wb_reg(wb_reg), .wb_data(wb_data), .mem_req(mem_req),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ack(mem_ack), .flags(flags),
        .mem_err(mem_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic setOp(input logic [3:0] op, input logic [3:0] d,
                         input logic [15:0] s1, input logic [15:0] s2);
        opcode = op; destReg = d; srcVal1 = s1; srcVal2 = s2;
    endtask

    initial begin
        rst = 1'b0; used1 = 1'b0; used2 = 1'b0; mem_ack = 1'b0;
        mem_rdata = '0; memAddr = '0;
        setOp(4'h0, 4'h0, 16'h0, 16'h0);
        #23;
        chk("rst_wb_en", {31'b0, wb_en}, 0);
        chk("rst_mem_req", {31'b0, mem_req}, 0);
        chk("rst_flags", {29'b0, flags}, 0);
        chk("rst_stall", {31'b0, stall}, 0);
        rst = 1'b1;
        tick();

        // ADD with carry out and zero result
        setOp(4'h1, 4'd3, 16'hFFFF, 16'h0001); #1;
        chk("add_stall", {31'b0, stall}, 0);
        tick();
        chk("add_wb_en", {31'b0, wb_en}, 1);
        chk("add_wb_reg", {28'b0, wb_reg}, 3);
        chk("add_wb_data", {16'b0, wb_data}, 32'h0000);
        chk("add_flags", {29'b0, flags}, 3'b011);

        // back-to-back ALU ops
        setOp(4'h3, 4'd6, 16'hA5A5, 16'h0FF0); tick();
        chk("and_wb_en", {31'b0, wb_en}, 1);
        chk("and_data", {16'b0, wb_data}, 32'h05A0);
        chk("and_flags", {29'b0, flags}, 3'b000);
        setOp(4'h5, 4'd7, 16'hFFFF, 16'h00FF); tick();
        chk("xor_wb_en", {31'b0, wb_en}, 1);
        chk("xor_data", {16'b0, wb_data}, 32'hFF00);
        chk("xor_flags", {29'b0, flags}, 3'b100);
        setOp(4'h9, 4'd8, 16'h8000, 16'h0004); tick();
        chk("sra_data", {16'b0, wb_data}, 32'hF800);
        setOp(4'h7, 4'd9, 16'h0001, 16'h000F); tick();
        chk("sll_data", {16'b0, wb_data}, 32'h8000);
        setOp(4'h8, 4'd10, 16'h8000, 16'h000F); tick();
        chk("srl_data", {16'b0, wb_data}, 32'h0001);
        chk("srl_flags", {29'b0, flags}, 3'b000);
        setOp(4'h4, 4'd1, 16'h0000, 16'h0000); tick();
        chk("or_zero_flags", {29'b0, flags}, 3'b001);

        // NOT ignores used2
        setOp(4'h6, 4'd11, 16'h0000, 16'h1234); used2 = 1'b1; #1;
        chk("not_no_stall", {31'b0, stall}, 0);
        tick();
        chk("not_data", {16'b0, wb_data}, 32'hFFFF);
        chk("not_flags", {29'b0, flags}, 3'b100);
        used2 = 1'b0;

        // reserved opcode: no wb, flags and wb data hold
        setOp(4'hA, 4'd2, 16'h1111, 16'h2222); used1 = 1'b1; #1;
        chk("rsv_no_stall", {31'b0, stall}, 0);
        tick();
        chk("rsv_wb_en", {31'b0, wb_en}, 0);
        chk("rsv_flags_hold", {29'b0, flags}, 3'b100);
        chk("rsv_data_hold", {16'b0, wb_data}, 32'hFFFF);
        used1 = 1'b0;

        // SUB with operand 2 hazard for two cycles
        setOp(4'h2, 4'd4, 16'h0005, 16'h0007); used2 = 1'b1; #1;
        chk("sub_haz_stall0", {31'b0, stall}, 1);
        tick();
        chk("sub_haz_wb0", {31'b0, wb_en}, 0);
        chk("sub_haz_stall1", {31'b0, stall}, 1);
        tick();
        chk("sub_haz_wb1", {31'b0, wb_en}, 0);
        used2 = 1'b0; #1;
        chk("sub_stall_clear", {31'b0, stall}, 0);
        tick();
        chk("sub_wb_en", {31'b0, wb_en}, 1);
        chk("sub_wb_reg", {28'b0, wb_reg}, 4);
        chk("sub_data", {16'b0, wb_data}, 32'hFFFE);
        chk("sub_flags", {29'b0, flags}, 3'b110);

        // LOAD, ack in third MEM cycle
        setOp(4'hE, 4'd5, 16'h0, 16'h0); memAddr = 8'h2A; #1;
        chk("ld_accept_stall", {31'b0, stall}, 1);
        tick();
        chk("ld_req", {31'b0, mem_req}, 1);
        chk("ld_we", {31'b0, mem_we}, 0);
        chk("ld_addr", {24'b0, mem_addr}, 32'h2A);
        chk("ld_stall_m1", {31'b0, stall}, 1);
        memAddr = 8'h00;
        tick();
        chk("ld_req_m2", {31'b0, mem_req}, 1);
        chk("ld_addr_m2", {24'b0, mem_addr}, 32'h2A);
        chk("ld_stall_m2", {31'b0, stall}, 1);
        chk("ld_no_wb_m2", {31'b0, wb_en}, 0);
        tick();
        mem_ack = 1'b1; mem_rdata = 16'hBEEF;
        tick();
        mem_ack = 1'b0; mem_rdata = 16'h0;
        setOp(4'h0, 4'd0, 16'h0, 16'h0); #1;
        chk("ld_req_drop", {31'b0, mem_req}, 0);
        chk("ld_stall_drop", {31'b0, stall}, 0);
        chk("ld_wb_en", {31'b0, wb_en}, 1);
        chk("ld_wb_reg", {28'b0, wb_reg}, 5);
        chk("ld_wb_data", {16'b0, wb_data}, 32'hBEEF);
        tick();
        chk("ld_wb_once", {31'b0, wb_en}, 0);

        // STORE, immediate ack
        setOp(4'hF, 4'd2, 16'h1234, 16'h0); memAddr = 8'h10;
        tick();
        chk("st_req", {31'b0, mem_req}, 1);
        chk("st_we", {31'b0, mem_we}, 1);
        chk("st_addr", {24'b0, mem_addr}, 32'h10);
        chk("st_wdata", {16'b0, mem_wdata}, 32'h1234);
        mem_ack = 1'b1;
        tick();
        mem_ack = 1'b0;
        setOp(4'h0, 4'd0, 16'h0, 16'h0); #1;
        chk("st_req_drop", {31'b0, mem_req}, 0);
        chk("st_no_wb", {31'b0, wb_en}, 0);
        chk("st_stall_drop", {31'b0, stall}, 0);
        tick();
        chk("st_no_wb2", {31'b0, wb_en}, 0);

        // LOAD timeout after 15 MEM cycles
        setOp(4'hE, 4'd6, 16'h0, 16'h0); memAddr = 8'h33;
        tick();
        chk("to_req_c1", {31'b0, mem_req}, 1);
        for (int i = 2; i <= 15; i++) begin
            tick();
            chk($sformatf("to_req_c%0d", i), {31'b0, mem_req}, 1);
        end
        chk("to_no_err_yet", {31'b0, mem_err}, 0);
        tick();
        setOp(4'h0, 4'd0, 16'h0, 16'h0); #1;
        chk("to_req_drop", {31'b0, mem_req}, 0);
        chk("to_err", {31'b0, mem_err}, 1);
        chk("to_no_wb", {31'b0, wb_en}, 0);
        chk("to_stall_drop", {31'b0, stall}, 0);
        tick();
        chk("to_err_sticky", {31'b0, mem_err}, 1);

        // reset in the middle of MEM
        setOp(4'hE, 4'd7, 16'h0, 16'h0); memAddr = 8'h44;
        tick();
        tick();
        chk("mr_req_before", {31'b0, mem_req}, 1);
        #2 rst = 1'b0; #1;
        chk("mr_req", {31'b0, mem_req}, 0);
        chk("mr_stall", {31'b0, stall}, 0);
        chk("mr_wb_en", {31'b0, wb_en}, 0);
        chk("mr_err", {31'b0, mem_err}, 0);
        setOp(4'h0, 4'd0, 16'h0, 16'h0);
        tick();
        rst = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("nop_no_wb", {31'b0, wb_en}, 0);
        end

        // ack arriving in the 15th MEM cycle completes normally
        setOp(4'hE, 4'd9, 16'h0, 16'h0); memAddr = 8'h55;
        tick();
        setOp(4'h0, 4'd0, 16'h0, 16'h0);
        for (int i = 2; i <= 14; i++) tick();
        chk("late_req_c14", {31'b0, mem_req}, 1);
        tick();
        chk("late_req_c15", {31'b0, mem_req}, 1);
        mem_ack = 1'b1; mem_rdata = 16'h5A5A;
        tick();
        mem_ack = 1'b0; mem_rdata = 16'h0; #1;
        chk("late_req_drop", {31'b0, mem_req}, 0);
        chk("late_err", {31'b0, mem_err}, 0);
        chk("late_wb_en", {31'b0, wb_en}, 1);
        chk("late_wb_reg", {28'b0, wb_reg}, 9);
        chk("late_wb_data", {16'b0, wb_data}, 32'h5A5A);
        tick();
        chk("late_wb_once", {31'b0, wb_en}, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/execute_and_writeback.md
Name: execute_and_writeback

Overview:
Third stage of the 3-stage pipeline: consumes the decoded opcode, destination register, operand values, memory address and operand in-use flags from the decode/operand-fetch stage. Executes ALU ops, performs LOAD/STORE through a req/ack data-memory port, and writes results back to the register file. Drives a stall back to fetch/decode on operand hazards and while a memory access is outstanding.

Parameters:
DATA_W, 16, operand/result width
ADDR_W, 8, data memory address width
MEM_TIMEOUT, 15, max cycles waiting for mem_ack before abort (1..255)

Ports:
clk  in  1  pipeline clock, rising edge
rst  in  1  asynchronous, active-low reset
opcode  in  4  decoded opcode
destReg  in  4  destination register (LOAD target / STORE source index)
srcVal1  in  DATA_W  operand 1 (STORE data)
srcVal2  in  DATA_W  operand 2
memAddr  in  ADDR_W  LOAD/STORE address
used1  in  1  operand 1 still in use (pending write)
used2  in  1  operand 2 still in use
stall  out  1  hold fetch/decode this cycle
wb_en  out  1  register-file write strobe, one cycle
wb_reg  out  4  register-file write index
wb_data  out  DATA_W  register-file write data
mem_req  out  1  memory request, held until ack
mem_we  out  1  1 = store, 0 = load; valid with mem_req
mem_addr  out  ADDR_W  memory address; valid with mem_req
mem_wdata  out  DATA_W  store data; valid with mem_req
mem_rdata  in  DATA_W  load data, valid with mem_ack
mem_ack  in  1  one-cycle completion pulse
flags  out  3  {negative, carry, zero} of last ALU op
mem_err  out  1  sticky timeout error

Behaviour:
- Reset (rst low, async): all outputs 0, FSM to IDLE, timeout counter 0, mem_err cleared; any in-flight request dropped immediately.
- Opcodes: 0000 NOP; 0001 ADD; 0010 SUB (src1-src2); 0011 AND; 0100 OR; 0101 XOR; 0110 NOT src1; 0111 SLL src1 by src2[3:0]; 1000 SRL; 1001 SRA; 1010-1101 reserved, treated as NOP; 1110 LOAD; 1111 STORE.
- Operand use: binary ALU ops read src1 and src2; NOT and STORE read src1 only; NOP/reserved/LOAD read none.
- Hazard: inputs are sampled at the rising clk edge in IDLE. If a read operand has its used flag high, stall=1 that cycle, no state change, no wb; the op re-evaluates each cycle until the flag clears.
- ALU: 1-cycle latency. The cycle after sampling, wb_en=1, wb_reg=destReg, wb_data=result. flags update on the same edge. carry = bit DATA_W of ADD, or borrow of SUB (src1<src2 unsigned); 0 for other ops. zero = result==0. negative = result MSB. Shift amounts >= DATA_W are impossible (4-bit). ALU ops never assert stall absent a hazard: back-to-back one per cycle.
- NOP/reserved: wb_en=0, flags hold.
- FSM IDLE -> MEM on LOAD/STORE: next edge mem_req=1, mem_we=(opcode==1111), mem_addr=memAddr, mem_wdata=srcVal1 (STORE); all held stable until ack. stall=1 throughout MEM, including the cycle the op is accepted.
- MEM -> IDLE on mem_ack: LOAD gives wb_en=1, wb_reg=destReg, wb_data=mem_rdata on the following cycle. STORE gives no wb. mem_req drops the cycle after ack. stall drops the same cycle mem_req drops.
- Timeout: counter increments each MEM cycle without ack. On reaching MEM_TIMEOUT, return to IDLE, mem_req=0, no wb, mem_err=1 (sticky until reset). An ack arriving in the timeout cycle wins: treated as a normal completion.
- wb_en is never high for more than one cycle per instruction. wb_reg/wb_data hold their last values when wb_en=0.

Decomposition:
- Shared package/header: opcode constants (OP_NOP..OP_STORE), FSM state encodings IDLE/MEM, flag bit positions.
- One natural sub-module: alu16 (combinational opcode/src1/src2 -> result, carry). FSM, hazard logic and writeback stay in the top module.

Test Plan:
- ADD src1=0xFFFF src2=0x0001 dest=3 -> next cycle wb_en=1, wb_reg=3, wb_data=0x0000, flags=carry=1 zero=1 negative=0.
- SUB 0x0005-0x0007 with used2=1 for 2 cycles -> stall=1 for 2 cycles, no wb; then wb_data=0xFFFE, carry=1, negative=1.
- LOAD memAddr=0x2A dest=5, ack after 3 cycles with rdata=0xBEEF -> mem_req=1, mem_we=0, mem_addr=0x2A held; stall high throughout; wb_en=1, wb_reg=5, wb_data=0xBEEF once.
- STORE memAddr=0x10 srcVal1=0x1234 -> mem_we=1, mem_wdata=0x1234; on ack, no wb_en; stall released.
- LOAD with no ack for MEM_TIMEOUT=15 cycles -> mem_req drops, mem_err=1, no wb. Ack exactly on cycle 15 -> normal completion, mem_err=0.
- rst low mid-MEM -> mem_req, stall, wb_en and mem_err go 0 immediately. After release, NOP stream produces no wb.
